// File: rtl/row_symext_packer.sv
// Row buffer that replays a stored raster row as {odd, even} sample pairs
// with whole-sample symmetric extension on both sides, for the row DWT stage.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting samples into the even/odd banks
// DROP  | row overflowed the banks; discard beats up to eol
// DRAIN | replaying left extension, body, right extension; input stalled
module row_symext_packer #(
  parameter int DataWidth       = 16,
  parameter int MaximumSideSize = 512,
  parameter int ExtPairs        = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     s_ready_o,
  input  logic                     s_valid_i,
  input  logic                     s_sof_i,
  input  logic                     s_eol_i,
  input  logic [DataWidth-1:0]     s_data_i,
  input  logic                     m_ready_i,
  output logic                     m_valid_o,
  output logic                     m_sof_o,
  output logic                     m_eol_o,
  output logic [2*DataWidth-1:0]   m_data_o,
  output logic                     err_o
);

  localparam int BankDepth = MaximumSideSize / 2;
  localparam int AW = (BankDepth > 1) ? $clog2(BankDepth) : 1;
  localparam int CW = $clog2(MaximumSideSize + 4 * ExtPairs) + 1;
  localparam logic [CW-1:0] ExtC    = CW'(ExtPairs);
  localparam logic [CW-1:0] MinLen  = CW'(2 * ExtPairs + 2);
  localparam logic [CW-1:0] LastIdx = CW'(MaximumSideSize - 1);
  localparam logic [AW-1:0] ExtA    = AW'(ExtPairs);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DROP  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] wcnt_q, rcnt_q, hw_q;
  logic          sof_q;
  logic          err_d;

  logic [DataWidth-1:0] ram_ev [BankDepth];
  logic [DataWidth-1:0] ram_od [BankDepth];
  logic [DataWidth-1:0] rd_ev_q, rd_od_q;
  logic                 rd_vld_q, rd_sof_q, rd_eol_q;

  logic [2*DataWidth-1:0] fifo_data_q [2];
  logic [1:0]             fifo_sof_q, fifo_eol_q;
  logic                   fifo_wp_q, fifo_rp_q;
  logic [1:0]             fifo_cnt_q;

  logic [CW-1:0] w_len, n_pairs;
  logic          row_ok, s_acc, pop, push, issue;
  logic [2:0]    occ;
  logic [AW-1:0] rc_a, hw_a, jr_a, ev_addr, od_addr;

  assign s_ready_o = (state_q != DRAIN);
  assign s_acc     = s_valid_i & s_ready_o;
  assign w_len     = wcnt_q + CW'(1);
  assign row_ok    = ~w_len[0] & (w_len >= MinLen);
  assign n_pairs   = hw_q + CW'(2 * ExtPairs);

  assign m_valid_o = (fifo_cnt_q != 2'd0);
  assign m_data_o  = fifo_data_q[fifo_rp_q];
  assign m_sof_o   = fifo_sof_q[fifo_rp_q];
  assign m_eol_o   = fifo_eol_q[fifo_rp_q];
  assign pop       = m_valid_o & m_ready_i;
  assign push      = rd_vld_q;

  // Skid slots plus the read in flight never exceed two entries.
  assign occ   = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_q};
  assign issue = (state_q == DRAIN) && (rcnt_q < n_pairs) &&
                 ((occ < 3'd2) || ((occ == 3'd2) && pop));

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (s_acc && s_eol_i) begin
          if (row_ok) state_d = DRAIN;
          else        err_d   = 1'b1;
        end else if (s_acc && (wcnt_q == LastIdx)) begin
          err_d   = 1'b1;
          state_d = DROP;
        end
      end
      DROP: begin
        if (s_acc && s_eol_i) state_d = FILL;
      end
      DRAIN: begin
        if (pop && m_eol_o) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Bank addresses in AW-bit modular arithmetic; a full-length row wraps hw to 0.
  always_comb begin
    rc_a    = rcnt_q[AW-1:0];
    hw_a    = hw_q[AW-1:0];
    jr_a    = rc_a - ExtA - hw_a;
    ev_addr = '0;
    od_addr = '0;
    if (rcnt_q < ExtC) begin
      ev_addr = ExtA - rc_a;
      od_addr = ExtA - rc_a - AW'(1);
    end else if (rcnt_q < ExtC + hw_q) begin
      ev_addr = rc_a - ExtA;
      od_addr = rc_a - ExtA;
    end else begin
      ev_addr = hw_a - jr_a - AW'(1);
      od_addr = hw_a - jr_a - AW'(2);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q         <= '0;
      rcnt_q         <= '0;
      hw_q           <= '0;
      sof_q          <= 1'b0;
      err_o          <= 1'b0;
      rd_vld_q       <= 1'b0;
      rd_sof_q       <= 1'b0;
      rd_eol_q       <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_sof_q     <= '0;
      fifo_eol_q     <= '0;
      fifo_wp_q      <= 1'b0;
      fifo_rp_q      <= 1'b0;
      fifo_cnt_q     <= '0;
    end else begin
      err_o <= err_d;
      if (state_q == FILL && s_acc) begin
        if (wcnt_q == '0) sof_q <= s_sof_i;
        if (s_eol_i || wcnt_q == LastIdx) wcnt_q <= '0;
        else                              wcnt_q <= wcnt_q + CW'(1);
        if (s_eol_i) hw_q <= w_len >> 1;
      end
      if (state_q != DRAIN) rcnt_q <= '0;
      else if (issue)       rcnt_q <= rcnt_q + CW'(1);
      rd_vld_q <= issue;
      rd_sof_q <= issue && (rcnt_q == '0) && sof_q;
      rd_eol_q <= issue && (rcnt_q == n_pairs - CW'(1));
      if (push) begin
        fifo_data_q[fifo_wp_q] <= {rd_od_q, rd_ev_q};
        fifo_sof_q[fifo_wp_q]  <= rd_sof_q;
        fifo_eol_q[fifo_wp_q]  <= rd_eol_q;
        fifo_wp_q              <= ~fifo_wp_q;
      end
      if (pop) fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == FILL && s_acc) begin
      if (wcnt_q[0]) ram_od[wcnt_q[AW:1]] <= s_data_i;
      else           ram_ev[wcnt_q[AW:1]] <= s_data_i;
    end
    if (issue) begin
      rd_ev_q <= ram_ev[ev_addr];
      rd_od_q <= ram_od[od_addr];
    end
  end

endmodule

// File: tb/tb_row_symext_packer.sv
// Directed bench for row_symext_packer: a sample-sequence reference model
// checked against every accepted output pair, plus pinned literal pairs.
module tb_row_symext_packer;

  localparam int T = 10;

  typedef struct packed {
    logic [31:0] d;
    logic        sof;
    logic        eol;
  } pair_t;
  typedef pair_t pair_q_t[$];
  typedef int    int_q_t[$];

  logic clk = 1'b0;
  logic rst;
  logic s_ready, s_valid, s_sof, s_eol;
  logic [15:0] s_data;
  logic m_ready, m_valid, m_sof, m_eol, err;
  logic [31:0] m_data;
  logic s2_ready, s2_valid, s2_sof, s2_eol;
  logic [15:0] s2_data;
  logic m2_ready, m2_valid, m2_sof, m2_eol, err2;
  logic [31:0] m2_data;

  int n_vec = 0, n_err = 0;
  pair_q_t exp_q, exp2_q;
  logic [31:0] obs_q[$], obs2_q[$];
  int valid_seen = 0, n_acc = 0, eol_cnt = 0, sof_cnt = 0, stall_cnt = 0;
  int err_pulses = 0, err2_pulses = 0, err2_at = -1, beats2 = 0, m2_seen = 0;
  bit bp_mode = 0;
  logic [3:0] bp_pat = 4'b1001;
  bit got_first = 0;
  time eol_t = 0, first_v_t = 0;

  always #(T/2) clk = ~clk;

  row_symext_packer dut (
    .clk_i(clk), .rst_i(rst),
    .s_ready_o(s_ready), .s_valid_i(s_valid), .s_sof_i(s_sof), .s_eol_i(s_eol), .s_data_i(s_data),
    .m_ready_i(m_ready), .m_valid_o(m_valid), .m_sof_o(m_sof), .m_eol_o(m_eol), .m_data_o(m_data),
    .err_o(err)
  );

  row_symext_packer #(.MaximumSideSize(16)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .s_ready_o(s2_ready), .s_valid_i(s2_valid), .s_sof_i(s2_sof), .s_eol_i(s2_eol), .s_data_i(s2_data),
    .m_ready_i(m2_ready), .m_valid_o(m2_valid), .m_sof_o(m2_sof), .m_eol_o(m2_eol), .m_data_o(m2_data),
    .err_o(err2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int_q_t ramp(input int base, input int w);
    int_q_t r;
    for (int k = 0; k < w; k++) r.push_back(base + k);
    return r;
  endfunction

  // Mirror the row about x[0] and x[W-1] (whole-sample), then cut into pairs.
  function automatic pair_q_t model_pairs(input int_q_t xs, input bit sof, input int ext);
    int e;
    int w;
    int seq[$];
    pair_q_t r;
    pair_t q;
    e = 2 * ext;
    w = xs.size();
    for (int k = e; k >= 1; k--) seq.push_back(xs[k]);
    for (int k = 0; k < w; k++) seq.push_back(xs[k]);
    for (int k = w - 2; k >= w - 1 - e; k--) seq.push_back(xs[k]);
    for (int p = 0; p < seq.size() / 2; p++) begin
      q.d   = {16'(seq[2*p+1]), 16'(seq[2*p])};
      q.sof = sof && (p == 0);
      q.eol = (p == seq.size() / 2 - 1);
      r.push_back(q);
    end
    return r;
  endfunction

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp_mode ? bp_pat[stall_idx() % 4] : 1'b1;
    end
  end

  int bp_idx = 0;
  function automatic int stall_idx();
    bp_idx++;
    return bp_idx;
  endfunction

  logic [31:0] held_d;
  logic held_s, held_e;
  bit held_v = 0;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 0;
    end else begin
      if (m_valid) begin
        valid_seen++;
        if (!got_first) begin
          got_first = 1;
          first_v_t = $time;
        end
        if (held_v) begin
          stall_cnt++;
          check("stall_hold", {m_sof, m_eol, m_data}, {held_s, held_e, held_d});
        end
        if (m_ready) begin
          held_v = 0;
          n_acc++;
          obs_q.push_back(m_data);
          if (m_eol) eol_cnt++;
          if (m_sof) sof_cnt++;
          if (exp_q.size() == 0) check("unexpected_pair", m_valid, 1'b0);
          else begin
            pair_t e;
            e = exp_q.pop_front();
            check("pair", {m_sof, m_eol, m_data}, {e.sof, e.eol, e.d});
          end
        end else begin
          held_v = 1;
          held_d = m_data;
          held_s = m_sof;
          held_e = m_eol;
        end
      end else begin
        if (held_v) check("valid_held", m_valid, 1'b1);
        held_v = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_pulses++;
      if (err2) begin
        err2_pulses++;
        err2_at = beats2;
      end
      if (m2_valid) begin
        m2_seen++;
        obs2_q.push_back(m2_data);
        if (exp2_q.size() == 0) check("unexpected_pair2", m2_valid, 1'b0);
        else begin
          pair_t e;
          e = exp2_q.pop_front();
          check("pair2", {m2_sof, m2_eol, m2_data}, {e.sof, e.eol, e.d});
        end
      end
    end
  end

  task automatic send_row(input int_q_t xs, input bit sof);
    int n;
    for (int i = 0; i < xs.size(); i++) begin
      n = 0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 16'(xs[i]);
      s_sof   = sof && (i == 0);
      s_eol   = (i == xs.size() - 1);
      while (!s_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!s_ready) check("s_ready_timeout", {63'd0, s_ready}, 64'd1);
      @(posedge clk);
      if (s_eol) eol_t = $time;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic send_row2(input int_q_t xs, input bit sof);
    int n;
    for (int i = 0; i < xs.size(); i++) begin
      n = 0;
      @(negedge clk);
      s2_valid = 1'b1;
      s2_data  = 16'(xs[i]);
      s2_sof   = sof && (i == 0);
      s2_eol   = (i == xs.size() - 1);
      while (!s2_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!s2_ready) check("s2_ready_timeout", {63'd0, s2_ready}, 64'd1);
      @(posedge clk);
      beats2++;
    end
    @(negedge clk);
    s2_valid = 1'b0;
    s2_sof   = 1'b0;
    s2_eol   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic start_row(input int_q_t xs, input bit sof);
    obs_q.delete();
    eol_cnt   = 0;
    sof_cnt   = 0;
    got_first = 0;
    exp_q     = model_pairs(xs, sof, 4);
  endtask

  initial begin
    int e0, v0, a0, n, lat;
    rst = 1'b1;
    s_valid = 0; s_sof = 0; s_eol = 0; s_data = '0;
    s2_valid = 0; s2_sof = 0; s2_eol = 0; s2_data = '0;
    m2_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_sof", m_sof, 1'b0);
    check("rst_m_eol", m_eol, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_m_data", m_data, 32'd0);

    // W=16 ramp from 100 with sof, no backpressure
    start_row(ramp(100, 16), 1);
    send_row(ramp(100, 16), 1);
    check("ready_low_drain", s_ready, 1'b0);
    wait_drain(200);
    check("ready_after_drain", s_ready, 1'b1);
    lat = int'((first_v_t - eol_t - T/2) / T);
    check("latency_le3", (lat <= 3), 1'b1);
    check("a_count", obs_q.size(), 16);
    if (obs_q.size() == 16) begin
      check("a_pair0", obs_q[0], {16'd107, 16'd108});
      check("a_pair4", obs_q[4], {16'd101, 16'd100});
      check("a_pair11", obs_q[11], {16'd115, 16'd114});
      check("a_pair12", obs_q[12], {16'd113, 16'd114});
      check("a_pair13", obs_q[13], {16'd111, 16'd112});
      check("a_pair15", obs_q[15], {16'd107, 16'd108});
    end
    check("a_eol_count", eol_cnt, 1);
    check("a_sof_count", sof_cnt, 1);

    // next row without sof
    start_row(ramp(200, 16), 0);
    send_row(ramp(200, 16), 0);
    wait_drain(200);
    check("b_sof_count", sof_cnt, 0);
    check("b_count", obs_q.size(), 16);

    // backpressure 1,0,0,1
    bp_mode = 1;
    stall_cnt = 0;
    start_row(ramp(300, 16), 1);
    send_row(ramp(300, 16), 1);
    wait_drain(400);
    bp_mode = 0;
    check("c_count", obs_q.size(), 16);
    check("c_stalled", (stall_cnt > 0), 1'b1);

    // illegal rows: odd length, then too short
    start_row(ramp(400, 9), 0);
    exp_q.delete();
    e0 = err_pulses; v0 = valid_seen;
    send_row(ramp(400, 9), 0);
    repeat (10) @(negedge clk);
    check("odd_err", err_pulses - e0, 1);
    check("odd_no_valid", valid_seen - v0, 0);
    e0 = err_pulses; v0 = valid_seen;
    send_row(ramp(400, 8), 0);
    repeat (10) @(negedge clk);
    check("short_err", err_pulses - e0, 1);
    check("short_no_valid", valid_seen - v0, 0);

    // smallest legal row
    start_row(ramp(100, 10), 0);
    send_row(ramp(100, 10), 0);
    wait_drain(200);
    check("w10_count", obs_q.size(), 13);
    if (obs_q.size() > 0) check("w10_pair0", obs_q[0], {16'd107, 16'd108});

    // reset after three accepted pairs
    start_row(ramp(600, 16), 1);
    a0 = n_acc;
    send_row(ramp(600, 16), 1);
    n = 0;
    while (n_acc - a0 < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_timeout", (n_acc - a0 >= 3), 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_valid", m_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", s_ready, 1'b1);
    v0 = valid_seen;
    repeat (30) @(negedge clk);
    check("rst_no_stale", valid_seen - v0, 0);

    start_row(ramp(700, 12), 1);
    send_row(ramp(700, 12), 1);
    wait_drain(200);
    check("recover_count", obs_q.size(), 14);

    // overflow on the 16-sample instance
    beats2 = 0;
    e0 = err2_pulses;
    v0 = m2_seen;
    send_row2(ramp(800, 20), 0);
    repeat (5) @(negedge clk);
    check("ovf_err", err2_pulses - e0, 1);
    check("ovf_err_beat", err2_at, 16);
    check("ovf_no_valid", m2_seen - v0, 0);
    obs2_q.delete();
    exp2_q = model_pairs(ramp(900, 12), 1, 4);
    send_row2(ramp(900, 12), 1);
    n = 0;
    while ((exp2_q.size() != 0 || m2_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ovf_drain_timeout", 64'(exp2_q.size()), 64'd0);
    check("ovf_next_count", obs2_q.size(), 14);
    if (obs2_q.size() > 0) check("ovf_next_pair0", obs2_q[0], {16'd907, 16'd908});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
